scmp_bus_ctl: RTL and testbench

Parametrised external bus-cycle sequencer for the SC/MP core family. It takes single-beat read/write requests from the core's microcode/datapath side and runs them on the multiplexed SC/MP-style bus: address pins, status/upper-address on the data bus during ADS, and RD/WR strobes. Beyond the fixed-timing bus it replaces, it adds configurable address width, ADS length, minimum strobe width, hold (wait-state) extension, back-to-back pipelined accept and optional BREQ/ENIN/ENOUT daisy-chain arbitration.

---
 rtl/scmp_bus_ctl.sv | 206 ++++++++++++++++++++
 tb/tb_scmp_bus_ctl.sv | 347 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/scmp_bus_ctl.sv
// scmp_bus_ctl: single-beat bus-cycle sequencer for the SC/MP core family.
// Runs one read or write per request on the multiplexed bus: status and
// upper address on the data pins while ADS_n is low, then an RD_n/WR_n
// strobe that can be stretched by hold_i, then one recovery cycle.
// Bus arbitration through the BREQ/ENIN/ENOUT daisy chain is optional.
//
// Request handshake: a request transfers on any rising edge where
// req_i && req_rdy_o. req_rdy_o is high only in IDLE and RECOV (and never
// while rst is high); req_i may be held with stable fields until accepted.
// Completion is a single-cycle rsp_valid_o pulse with no back-pressure.
module scmp_bus_ctl #(
    parameter int ADDR_W   = 12,
    parameter int ADS_CYC  = 1,
    parameter int MIN_WAIT = 2,
    parameter int USE_ARB  = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_i,
    input  logic              req_we_i,
    input  logic [ADDR_W-1:0] req_addr_i,
    input  logic [7:0]        req_wdata_i,
    input  logic [3:0]        req_flags_i,
    output logic              req_rdy_o,
    output logic              rsp_valid_o,
    output logic [7:0]        rsp_rdata_o,
    output logic [11:0]       addr_o,
    input  logic [7:0]        D_i,
    output logic [7:0]        D_o,
    output logic              D_oe,
    output logic              ADS_n,
    output logic              RD_n,
    output logic              WR_n,
    input  logic              hold_i,
    output logic              breq_o,
    input  logic              enin_i,
    output logic              enout_o,
    output logic [2:0]        dbg_state_o
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ARB   = 3'd1,
        S_ADS   = 3'd2,
        S_STRB  = 3'd3,
        S_RECOV = 3'd4
    } state_t;

    state_t      r_state;
    logic        r_we;
    logic [7:0]  r_wdata;
    logic [7:0]  r_hdr;     // status/upper-address byte shown during ADS
    logic [11:0] r_addr;
    logic [3:0]  r_cnt;     // cycles spent in the current ADS/STRB state

    logic [3:0]  w_req_hi;
    logic [7:0]  w_req_hdr;

    // Upper address bits only exist for widths above 12; otherwise the nibble is zero.
    generate
        if (ADDR_W > 12) begin : g_hi
            assign w_req_hi = 4'(req_addr_i[ADDR_W-1:12]);
        end else begin : g_no_hi
            assign w_req_hi = 4'h0;
        end
    endgenerate

    assign w_req_hdr   = {req_flags_i, w_req_hi};
    assign dbg_state_o = r_state;

    // Ready in IDLE and RECOV only; held low during reset.
    always_comb begin
        req_rdy_o = !rst && ((r_state == S_IDLE) || (r_state == S_RECOV));
    end

    // Grant passes downstream only when this block neither wants nor owns the bus.
    always_comb begin
        enout_o = 1'b0;
        if (!rst) begin
            if (USE_ARB != 0) begin
                enout_o = enin_i && (r_state == S_IDLE) && !req_i;
            end else begin
                enout_o = enin_i;
            end
        end
    end

    // Bus cycle sequencer; every bus pin is a register updated here.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_we        <= 1'b0;
            r_wdata     <= 8'h00;
            r_hdr       <= 8'h00;
            r_addr      <= 12'h000;
            r_cnt       <= 4'd0;
            ADS_n       <= 1'b1;
            RD_n        <= 1'b1;
            WR_n        <= 1'b1;
            D_oe        <= 1'b0;
            D_o         <= 8'h00;
            addr_o      <= 12'h000;
            breq_o      <= 1'b0;
            rsp_valid_o <= 1'b0;
            rsp_rdata_o <= 8'h00;
        end else begin
            rsp_valid_o <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (req_i) begin
                        r_we    <= req_we_i;
                        r_wdata <= req_wdata_i;
                        r_hdr   <= w_req_hdr;
                        r_addr  <= req_addr_i[11:0];
                        if (USE_ARB != 0) begin
                            r_state <= S_ARB;
                            breq_o  <= 1'b1;
                        end else begin
                            r_state <= S_ADS;
                            r_cnt   <= 4'd1;
                            ADS_n   <= 1'b0;
                            D_oe    <= 1'b1;
                            D_o     <= w_req_hdr;
                            addr_o  <= req_addr_i[11:0];
                        end
                    end
                end

                S_ARB: begin
                    // Wait for the grant as long as it takes.
                    if (enin_i) begin
                        r_state <= S_ADS;
                        r_cnt   <= 4'd1;
                        ADS_n   <= 1'b0;
                        D_oe    <= 1'b1;
                        D_o     <= r_hdr;
                        addr_o  <= r_addr;
                    end
                end

                S_ADS: begin
                    if (r_cnt == 4'(ADS_CYC)) begin
                        r_state <= S_STRB;
                        r_cnt   <= 4'd1;
                        ADS_n   <= 1'b1;
                        if (r_we) begin
                            WR_n <= 1'b0;
                            D_oe <= 1'b1;
                            D_o  <= r_wdata;
                        end else begin
                            RD_n <= 1'b0;
                            D_oe <= 1'b0;
                            D_o  <= 8'h00;
                        end
                    end else begin
                        r_cnt <= r_cnt + 4'd1;
                    end
                end

                S_STRB: begin
                    // Counter stops at MIN_WAIT; from then on hold_i alone stretches the strobe.
                    if (r_cnt >= 4'(MIN_WAIT)) begin
                        if (!hold_i) begin
                            r_state     <= S_RECOV;
                            RD_n        <= 1'b1;
                            WR_n        <= 1'b1;
                            rsp_valid_o <= 1'b1;
                            if (!r_we) begin
                                rsp_rdata_o <= D_i;
                            end
                        end
                    end else begin
                        r_cnt <= r_cnt + 4'd1;
                    end
                end

                S_RECOV: begin
                    // Write data stays driven here as data hold time.
                    if (req_i) begin
                        // Pipelined accept: keep the bus and go straight to ADS.
                        r_we    <= req_we_i;
                        r_wdata <= req_wdata_i;
                        r_hdr   <= w_req_hdr;
                        r_addr  <= req_addr_i[11:0];
                        r_state <= S_ADS;
                        r_cnt   <= 4'd1;
                        ADS_n   <= 1'b0;
                        D_oe    <= 1'b1;
                        D_o     <= w_req_hdr;
                        addr_o  <= req_addr_i[11:0];
                    end else begin
                        r_state <= S_IDLE;
                        breq_o  <= 1'b0;
                        D_oe    <= 1'b0;
                        D_o     <= 8'h00;
                    end
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_scmp_bus_ctl.sv
// Bench for scmp_bus_ctl. Instance 0: defaults (ADDR_W=12, no arbitration).
// Instance 1: ADDR_W=16 with daisy-chain arbitration enabled.
`timescale 1ns/1ps
module tb_scmp_bus_ctl;

    localparam int ADS_CYC  = 1;
    localparam int MIN_WAIT = 2;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- DUT signals (index = instance) ----------------
    logic        rst[2];
    logic        req[2];
    logic        req_we[2];
    logic [11:0] req_addr_a;
    logic [15:0] req_addr_b;
    logic [7:0]  req_wdata[2];
    logic [3:0]  req_flags[2];
    logic        req_rdy[2];
    logic        rsp_valid[2];
    logic [7:0]  rsp_rdata[2];
    logic [11:0] addr_pins[2];
    logic [7:0]  d_in[2];
    logic [7:0]  d_out[2];
    logic        d_oe[2];
    logic        ads_n[2];
    logic        rd_n[2];
    logic        wr_n[2];
    logic        hold[2];
    logic        breq[2];
    logic        enin[2];
    logic        enout[2];
    logic [2:0]  dbg[2];

    scmp_bus_ctl #(.ADDR_W(12), .ADS_CYC(ADS_CYC), .MIN_WAIT(MIN_WAIT), .USE_ARB(0)) u_dut_a (
        .clk(clk), .rst(rst[0]), .req_i(req[0]), .req_we_i(req_we[0]),
        .req_addr_i(req_addr_a), .req_wdata_i(req_wdata[0]), .req_flags_i(req_flags[0]),
        .req_rdy_o(req_rdy[0]), .rsp_valid_o(rsp_valid[0]), .rsp_rdata_o(rsp_rdata[0]),
        .addr_o(addr_pins[0]), .D_i(d_in[0]), .D_o(d_out[0]), .D_oe(d_oe[0]),
        .ADS_n(ads_n[0]), .RD_n(rd_n[0]), .WR_n(wr_n[0]), .hold_i(hold[0]),
        .breq_o(breq[0]), .enin_i(enin[0]), .enout_o(enout[0]), .dbg_state_o(dbg[0])
    );

    scmp_bus_ctl #(.ADDR_W(16), .ADS_CYC(ADS_CYC), .MIN_WAIT(MIN_WAIT), .USE_ARB(1)) u_dut_b (
        .clk(clk), .rst(rst[1]), .req_i(req[1]), .req_we_i(req_we[1]),
        .req_addr_i(req_addr_b), .req_wdata_i(req_wdata[1]), .req_flags_i(req_flags[1]),
        .req_rdy_o(req_rdy[1]), .rsp_valid_o(rsp_valid[1]), .rsp_rdata_o(rsp_rdata[1]),
        .addr_o(addr_pins[1]), .D_i(d_in[1]), .D_o(d_out[1]), .D_oe(d_oe[1]),
        .ADS_n(ads_n[1]), .RD_n(rd_n[1]), .WR_n(wr_n[1]), .hold_i(hold[1]),
        .breq_o(breq[1]), .enin_i(enin[1]), .enout_o(enout[1]), .dbg_state_o(dbg[1])
    );

    // ---------------- checking ----------------
    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // ---------------- scoreboard ----------------
    typedef struct packed {
        logic        dut;
        logic        we;
        logic [7:0]  data;   // read data for reads, write data for writes
        logic [7:0]  hdr;    // D_o during ADS
        logic [11:0] addr;
        logic [7:0]  lat;    // cycles from accept edge to rsp_valid_o
        logic [7:0]  strb;   // strobe-low cycles
    } exp_t;
    localparam int EXP_W = $bits(exp_t);

    logic [EXP_W-1:0] exp_q[$];
    int               acc_q[$];      // cycle numbers at which requests were accepted
    int               rsp_cyc_q[$];  // cycle numbers of rsp_valid_o pulses

    int         ads_cnt[2];
    int         strb_cnt[2];
    logic [7:0] hdr_seen[2];
    logic [11:0] addr_seen[2];
    logic [7:0] wdata_seen[2];
    int         viol = 0;

    // Bus monitor: sampled mid-cycle, away from the active edge.
    always @(negedge clk) begin
        exp_t e;
        int   a;
        for (int d = 0; d < 2; d++) begin
            if (rst[d]) begin
                ads_cnt[d]  = 0;
                strb_cnt[d] = 0;
            end else begin
                if (req[d] && req_rdy[d]) acc_q.push_back(cyc);
                if (!ads_n[d] && (!rd_n[d] || !wr_n[d])) viol++;
                if (!rd_n[d] && !wr_n[d]) viol++;
                if (!ads_n[d]) begin
                    if (ads_cnt[d] == 0) begin
                        hdr_seen[d]  = d_out[d];
                        addr_seen[d] = addr_pins[d];
                    end
                    if (!d_oe[d]) viol++;
                    ads_cnt[d]++;
                end
                if (!rd_n[d] || !wr_n[d]) begin
                    strb_cnt[d]++;
                    if (!wr_n[d]) begin
                        wdata_seen[d] = d_out[d];
                        if (!d_oe[d]) viol++;
                    end else if (d_oe[d]) begin
                        viol++;
                    end
                end
                if (rsp_valid[d]) begin
                    rsp_cyc_q.push_back(cyc);
                    if (exp_q.size() == 0 || acc_q.size() == 0) begin
                        check("unexpected_rsp", 32'(rsp_valid[d]), 32'd0);
                    end else begin
                        e = exp_q.pop_front();
                        a = acc_q.pop_front();
                        check("rsp_dut", 32'(d), 32'(e.dut));
                        check("latency", 32'(cyc - a), 32'(e.lat));
                        check("ads_len", 32'(ads_cnt[d]), 32'(ADS_CYC));
                        check("ads_hdr", 32'(hdr_seen[d]), 32'(e.hdr));
                        check("ads_addr", 32'(addr_seen[d]), 32'(e.addr));
                        check("recov_addr", 32'(addr_pins[d]), 32'(e.addr));
                        check("strb_len", 32'(strb_cnt[d]), 32'(e.strb));
                        if (e.we) begin
                            check("wr_data", 32'(wdata_seen[d]), 32'(e.data));
                            check("recov_oe", 32'(d_oe[d]), 32'd1);
                            check("recov_wdata", 32'(d_out[d]), 32'(e.data));
                        end else begin
                            check("rd_data", 32'(rsp_rdata[d]), 32'(e.data));
                            check("recov_oe", 32'(d_oe[d]), 32'd0);
                        end
                    end
                    ads_cnt[d]  = 0;
                    strb_cnt[d] = 0;
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic issue(input int d, input logic we, input logic [15:0] addr,
                         input logic [7:0] wdata, input logic [3:0] flags,
                         input logic [7:0] rdata, input int lat, input int strb);
        exp_t e;
        int   n;
        req[d]       = 1'b1;
        req_we[d]    = we;
        req_wdata[d] = wdata;
        req_flags[d] = flags;
        if (d == 0) req_addr_a = addr[11:0];
        else        req_addr_b = addr;
        n = 0;
        @(negedge clk);
        while (!req_rdy[d] && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!req_rdy[d]) check("rdy_timeout", 32'(req_rdy[d]), 32'd1);
        e.dut  = (d == 1);
        e.we   = we;
        e.data = we ? wdata : rdata;
        e.hdr  = {flags, (d == 1) ? addr[15:12] : 4'h0};
        e.addr = addr[11:0];
        e.lat  = 8'(lat);
        e.strb = 8'(strb);
        exp_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic wait_rsp();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            @(posedge clk);
            n++;
        end
        if (exp_q.size() != 0) begin
            check("rsp_timeout", 32'(exp_q.size()), 32'd0);
            exp_q.delete();
            acc_q.delete();
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        logic arb_ok;
        for (int d = 0; d < 2; d++) begin
            rst[d] = 1'b1; req[d] = 1'b0; req_we[d] = 1'b0; req_wdata[d] = 8'h00;
            req_flags[d] = 4'h0; d_in[d] = 8'h00; hold[d] = 1'b0; enin[d] = 1'b1;
        end
        req_addr_a = 12'h000;
        req_addr_b = 16'h0000;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            check("rst_ads_n", 32'(ads_n[d]), 32'd1);
            check("rst_rd_n", 32'(rd_n[d]), 32'd1);
            check("rst_wr_n", 32'(wr_n[d]), 32'd1);
            check("rst_d_oe", 32'(d_oe[d]), 32'd0);
            check("rst_d_o", 32'(d_out[d]), 32'd0);
            check("rst_addr", 32'(addr_pins[d]), 32'd0);
            check("rst_breq", 32'(breq[d]), 32'd0);
            check("rst_rsp_valid", 32'(rsp_valid[d]), 32'd0);
            check("rst_rdata", 32'(rsp_rdata[d]), 32'd0);
            check("rst_req_rdy", 32'(req_rdy[d]), 32'd0);
            check("rst_enout", 32'(enout[d]), 32'd0);
        end
        @(posedge clk);
        #1;
        rst[0] = 1'b0;
        rst[1] = 1'b0;
        @(negedge clk);
        check("idle_rdy_a", 32'(req_rdy[0]), 32'd1);
        check("idle_enout_a", 32'(enout[0]), 32'd1);
        check("idle_enout_b_hi", 32'(enout[1]), 32'd1);
        enin[1] = 1'b0;
        #1;
        check("idle_enout_b_lo", 32'(enout[1]), 32'd0);
        enin[1] = 1'b1;
        @(posedge clk);
        #1;

        // Default read: 0x5A3, flags 0001, bus data 0xC7
        d_in[0] = 8'hC7;
        issue(0, 1'b0, 16'h05A3, 8'h00, 4'b0001, 8'hC7, 4, 2);
        req[0] = 1'b0;
        wait_rsp();

        // hold_i is high at the first exit check only, so the strobe stretches
        // from 2 to 3 cycles; read data is taken on the edge where hold_i is 0.
        issue(0, 1'b0, 16'h0321, 8'h00, 4'b0010, 8'hA5, 5, 3);
        req[0] = 1'b0;
        @(posedge clk); #1; hold[0] = 1'b1; d_in[0] = 8'h11;   // STRB cycle 1
        @(posedge clk); #1; d_in[0] = 8'h22;                   // STRB cycle 2
        @(posedge clk); #1; hold[0] = 1'b0; d_in[0] = 8'hA5;   // STRB cycle 3
        @(posedge clk); #1; d_in[0] = 8'h33;                   // RECOV
        wait_rsp();

        // Back-to-back reads: second accepted in RECOV of the first
        d_in[0] = 8'h5E;
        rsp_cyc_q.delete();
        issue(0, 1'b0, 16'h0123, 8'h00, 4'b0010, 8'h5E, 4, 2);
        issue(0, 1'b0, 16'h07FF, 8'h00, 4'b0100, 8'h5E, 4, 2);
        req[0] = 1'b0;
        wait_rsp();
        if (rsp_cyc_q.size() == 2) check("b2b_interval", 32'(rsp_cyc_q[1] - rsp_cyc_q[0]), 32'd4);
        else check("b2b_count", 32'(rsp_cyc_q.size()), 32'd2);

        // Wide address write with grant present: one ARB cycle, header 0x0B
        enin[1] = 1'b1;
        issue(1, 1'b1, 16'hBEEF, 8'h3C, 4'b0000, 8'h00, 5, 2);
        req[1] = 1'b0;
        wait_rsp();

        // Arbitration: requesting blocks the grant chain, then grant withheld
        req[1] = 1'b1;
        #1;
        check("req_blocks_enout", 32'(enout[1]), 32'd0);
        enin[1] = 1'b0;
        d_in[1] = 8'h96;
        // Grant low across 5 edges after accept: 6 ARB cycles in total
        issue(1, 1'b0, 16'h00A5, 8'h00, 4'b1000, 8'h96, 10, 2);
        req[1] = 1'b0;
        arb_ok = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (!(breq[1] === 1'b1 && enout[1] === 1'b0 && ads_n[1] === 1'b1)) arb_ok = 1'b0;
            @(posedge clk);
            #1;
        end
        check("arb_wait", 32'(arb_ok), 32'd1);
        enin[1] = 1'b1;
        @(negedge clk);
        check("arb_breq", 32'(breq[1]), 32'd1);
        check("arb_enout_granted", 32'(enout[1]), 32'd0);
        check("arb_no_ads", 32'(ads_n[1]), 32'd1);
        @(posedge clk);
        #1;
        @(negedge clk);
        check("arb_ads_next", 32'(ads_n[1]), 32'd0);
        @(posedge clk);
        #1;
        wait_rsp();
        @(negedge clk);
        check("post_breq", 32'(breq[1]), 32'd0);
        check("post_enout", 32'(enout[1]), 32'd1);
        @(posedge clk);
        #1;

        // Reset in the second strobe cycle of a write
        issue(0, 1'b1, 16'h02C4, 8'h81, 4'b0000, 8'h00, 4, 2);
        req[0] = 1'b0;
        @(posedge clk); #1;   // STRB cycle 1
        @(negedge clk);
        check("pre_rst_wr_n", 32'(wr_n[0]), 32'd0);
        @(posedge clk); #1;   // STRB cycle 2
        rst[0] = 1'b1;
        exp_q.delete();
        acc_q.delete();
        @(posedge clk); #1;
        @(negedge clk);
        check("abort_wr_n", 32'(wr_n[0]), 32'd1);
        check("abort_d_oe", 32'(d_oe[0]), 32'd0);
        check("abort_rsp", 32'(rsp_valid[0]), 32'd0);
        check("abort_state", 32'(dbg[0]), 32'd0);
        @(posedge clk); #1;
        rst[0] = 1'b0;
        @(negedge clk);
        check("abort_no_rsp", 32'(rsp_valid[0]), 32'd0);
        @(posedge clk); #1;
        d_in[0] = 8'h42;
        issue(0, 1'b0, 16'h03F0, 8'h00, 4'b0000, 8'h42, 4, 2);
        req[0] = 1'b0;
        wait_rsp();
        repeat (3) @(posedge clk);
        @(negedge clk);

        check("bus_rules", 32'(viol), 32'd0);
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
